// File: rtl/shift_engine.sv
// Parametrised multi-mode shift register (LSR/ASR/LSL, optional ROR) with busy/done handshake.
// Optional feature: define SHIFT_ENGINE_ROTATE_EN to make op 11 rotate right (otherwise it is LSR).
module shift_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] load_val,
    input  logic             load_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] w_q_step;

    // One single-bit step of the latched operation; ASR fills from the current MSB of q.
    always_comb begin
        w_q_step = r_q;
        case (r_op)
            2'b01:   w_q_step = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            2'b10:   w_q_step = {r_q[WIDTH-2:0], 1'b0};
`ifdef SHIFT_ENGINE_ROTATE_EN
            2'b11:   w_q_step = {r_q[0], r_q[WIDTH-1:1]};
`endif
            default: w_q_step = {1'b0, r_q[WIDTH-1:1]};
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_op    <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!load_n) begin
                        r_q <= load_val;
                    end else if (start) begin
                        r_op    <= op;
                        r_cnt   <= amount;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_q   <= w_q_step;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs come straight from flops or the state register, never from inputs.
    assign q    = r_q;
    assign busy = (r_state == ST_SHIFT);
    assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine: directed cases plus random ops against a whole-amount model.
module tb_shift_engine;

    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  load_val;
    logic          load_n;
    logic          start;
    logic [1:0]    op;
    logic [CW-1:0] amount;
    logic [W-1:0]  q;
    logic          busy;
    logic          done;

    logic [3:0]    load_val4;
    logic          load_n4;
    logic          start4;
    logic [3:0]    q4;
    logic          busy4;
    logic          done4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_engine #(.WIDTH(W), .CNT_W(CW)) u_dut (
        .clk(clk), .reset_n(reset_n), .load_val(load_val), .load_n(load_n),
        .start(start), .op(op), .amount(amount), .q(q), .busy(busy), .done(done)
    );

    shift_engine #(.WIDTH(4), .CNT_W(CW)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .load_val(load_val4), .load_n(load_n4),
        .start(start4), .op(op), .amount(amount), .q(q4), .busy(busy4), .done(done4)
    );

    // Result of shifting v by the whole amount a at once, for a w-bit register.
    function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [1:0] o,
                                              input int a, input int w);
        logic [31:0] mask;
        logic [31:0] res;
        int r;
        mask = (32'h1 << w) - 32'h1;
        v    = v & mask;
        case (o)
            2'b01:   res = v[w-1] ? ((v >> a) | (mask & ~(mask >> a))) : (v >> a);
            2'b10:   res = (v << a) & mask;
`ifdef SHIFT_ENGINE_ROTATE_EN
            2'b11: begin
                r   = a % w;
                res = ((v >> r) | (v << (w - r))) & mask;
            end
`endif
            default: res = v >> a;
        endcase
        return res;
    endfunction

    task automatic do_load(input logic [W-1:0] val);
        @(negedge clk);
        load_val = val;
        load_n   = 1'b0;
        @(negedge clk);
        load_n   = 1'b1;
    endtask

    // Starts an op and observes a fixed window of a+3 cycles after the start edge.
    task automatic run_op(input logic [1:0] o, input int a, input bit disturb,
                          output int busy_n, output int done_n, output int done_idx,
                          output logic [W-1:0] q_at_a, output logic [W-1:0] q_end);
        @(negedge clk);
        op     = o;
        amount = a[CW-1:0];
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_n   = 0;
        done_n   = 0;
        done_idx = -1;
        q_at_a   = '0;
        for (int i = 0; i <= a + 2; i++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_idx < 0) done_idx = i;
            end
            if (i == a) q_at_a = q;
            if (disturb && i == 1) begin
                start    = 1'b1;
                load_n   = 1'b0;
                load_val = 8'hFF;
                op       = 2'b10;
                amount   = 3'd1;
            end else if (disturb && i == 2) begin
                start  = 1'b0;
                load_n = 1'b1;
            end
            if (i < a + 2) @(negedge clk);
        end
        q_end = q;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #12;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected 00", q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_load;
        do_load(8'hB4);
        checks++; if (q !== 8'hB4) begin errors++; $display("FAIL load_q: got %h expected b4", q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy: got %b expected 0", busy); end
        // load has priority over a simultaneous start
        @(negedge clk);
        load_val = 8'h3C; load_n = 1'b0; start = 1'b1; op = 2'b00; amount = 3'd3;
        @(negedge clk);
        load_n = 1'b1; start = 1'b0;
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL load_prio_q: got %h expected 3c", q); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL load_prio_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_lsr;
        int bn, dn, di;
        logic [W-1:0] qa, qe;
        do_load(8'hB4);
        run_op(2'b00, 3, 1'b0, bn, dn, di, qa, qe);
        checks++; if (bn !== 4) begin errors++; $display("FAIL lsr_busy_cycles: got %0d expected 4", bn); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL lsr_done_count: got %0d expected 1", dn); end
        checks++; if (di !== 4) begin errors++; $display("FAIL lsr_done_pos: got %0d expected 4", di); end
        checks++; if (qa !== 8'h16) begin errors++; $display("FAIL lsr_q_at_k3: got %h expected 16", qa); end
        checks++; if (qe !== 8'h16) begin errors++; $display("FAIL lsr_q_held: got %h expected 16", qe); end
    endtask

    task automatic test_asr_lsl;
        int bn, dn, di;
        logic [W-1:0] qa, qe;
        do_load(8'hB4);
        run_op(2'b01, 2, 1'b0, bn, dn, di, qa, qe);
        checks++; if (qe !== 8'hED) begin errors++; $display("FAIL asr2: got %h expected ed", qe); end
        do_load(8'hB4);
        run_op(2'b10, 1, 1'b0, bn, dn, di, qa, qe);
        checks++; if (qe !== 8'h68) begin errors++; $display("FAIL lsl1: got %h expected 68", qe); end
        do_load(8'h80);
        run_op(2'b01, 7, 1'b0, bn, dn, di, qa, qe);
        checks++; if (qe !== 8'hFF) begin errors++; $display("FAIL asr7: got %h expected ff", qe); end
        checks++; if (bn !== 8 || dn !== 1) begin
            errors++; $display("FAIL asr7_handshake: got busy=%0d done=%0d expected 8 1", bn, dn);
        end
    endtask

    task automatic test_rotate;
        int bn, dn, di, b4, d4;
        logic [W-1:0] qa, qe, exp8;
        logic [3:0] exp4;
`ifdef SHIFT_ENGINE_ROTATE_EN
        exp8 = 8'hC0; exp4 = 4'h3;
`else
        exp8 = 8'h40; exp4 = 4'h0;
`endif
        do_load(8'h81);
        run_op(2'b11, 1, 1'b0, bn, dn, di, qa, qe);
        checks++; if (qe !== exp8) begin errors++; $display("FAIL op11_w8: got %h expected %h", qe, exp8); end
        @(negedge clk);
        load_val4 = 4'h9; load_n4 = 1'b0;
        @(negedge clk);
        load_n4 = 1'b1; op = 2'b11; amount = 3'd7; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; b4 = 0; d4 = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy4) b4++;
            if (done4) d4++;
            @(negedge clk);
        end
        checks++; if (q4 !== exp4) begin errors++; $display("FAIL op11_w4_wrap: got %h expected %h", q4, exp4); end
        checks++; if (b4 !== 8 || d4 !== 1) begin
            errors++; $display("FAIL op11_w4_handshake: got busy=%0d done=%0d expected 8 1", b4, d4);
        end
    endtask

    task automatic test_zero_and_ignored;
        int bn, dn, di;
        logic [W-1:0] qa, qe;
        do_load(8'h5A);
        run_op(2'b00, 0, 1'b0, bn, dn, di, qa, qe);
        checks++; if (qe !== 8'h5A) begin errors++; $display("FAIL zero_q: got %h expected 5a", qe); end
        checks++; if (bn !== 1) begin errors++; $display("FAIL zero_busy: got %0d expected 1", bn); end
        checks++; if (di !== 1 || dn !== 1) begin
            errors++; $display("FAIL zero_done: got pos=%0d count=%0d expected 1 1", di, dn);
        end
        do_load(8'hB4);
        run_op(2'b00, 5, 1'b1, bn, dn, di, qa, qe);
        checks++; if (qe !== 8'h05) begin errors++; $display("FAIL ignored_q: got %h expected 05", qe); end
        checks++; if (bn !== 6 || dn !== 1) begin
            errors++; $display("FAIL ignored_handshake: got busy=%0d done=%0d expected 6 1", bn, dn);
        end
    endtask

    task automatic test_reset_mid;
        int dn, bn;
        do_load(8'hB4);
        @(negedge clk);
        op = 2'b00; amount = 3'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL midreset_q: got %h expected 00", q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        @(negedge clk);
        reset_n = 1'b1;
        dn = 0; bn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dn++;
            if (busy) bn++;
        end
        checks++; if (dn !== 0 || bn !== 0) begin
            errors++; $display("FAIL midreset_no_done: got done=%0d busy=%0d expected 0 0", dn, bn);
        end
    endtask

    task automatic test_random;
        int bn, dn, di, a;
        logic [1:0] o;
        logic [W-1:0] v, qa, qe, exp;
        for (int n = 0; n < 24; n++) begin
            v = W'($urandom);
            o = 2'($urandom_range(0, 3));
            a = $urandom_range(0, 7);
            exp = W'(ref_shift({24'h0, v}, o, a, W));
            do_load(v);
            run_op(o, a, 1'b0, bn, dn, di, qa, qe);
            checks++; if (qe !== exp) begin
                errors++; $display("FAIL rand_q: v=%h op=%0d amt=%0d got %h expected %h", v, o, a, qe, exp);
            end
            checks++; if (bn !== a + 1 || dn !== 1 || di !== a + 1) begin
                errors++; $display("FAIL rand_handshake: amt=%0d got busy=%0d done=%0d pos=%0d expected %0d 1 %0d",
                                   a, bn, dn, di, a + 1, a + 1);
            end
        end
    endtask

    initial begin
        load_val = '0; load_n = 1'b1; start = 1'b0; op = 2'b00; amount = '0;
        load_val4 = '0; load_n4 = 1'b1; start4 = 1'b0;
        test_reset;
        test_load;
        test_lsr;
        test_asr_lsl;
        test_rotate;
        test_zero_and_ignored;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
